fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 19 +
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_queue.sv | 139 +++++++++++++
 tb/tb_fetch_queue.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch definitions: queue entry layout, reset PC, instruction size, fetch states.
package fetch_queue_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

    typedef enum logic [1:0] {
        FS_RESET,
        FS_IDLE,
        FS_WAIT,
        FS_SQUASH
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: decode-side controls, memory request/response and head-of-queue outputs.
interface fetch_queue_if #(
    parameter int unsigned FETCH_W = 2
);
    logic                   STALL;
    logic                   Request_Alt_PC;
    logic [31:0]            Alt_PC;
    logic                   Req_valid;
    logic [31:0]            Req_addr;
    logic                   Req_ready;
    logic                   Resp_valid;
    logic [32*FETCH_W-1:0]  Resp_data;
    logic [31:0]            Instr1_OUT;
    logic [31:0]            Instr_PC_OUT;
    logic [31:0]            Instr_PC_Plus4;
    logic                   Out_valid;

    modport master (
        input  STALL, Request_Alt_PC, Alt_PC, Req_ready, Resp_valid, Resp_data,
        output Req_valid, Req_addr, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Out_valid
    );

    modport slave (
        output STALL, Request_Alt_PC, Alt_PC, Req_ready, Resp_valid, Resp_data,
        input  Req_valid, Req_addr, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Out_valid
    );
endinterface

// File: rtl/fetch_fifo.sv
// Multi-write / single-read entry FIFO with wrap-around pointers one bit wider than the index.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned WR_N  = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  fq_entry_t              wr_data [WR_N],
    input  logic                   rd_en,
    output fq_entry_t              rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    fq_entry_t        mem_q [DEPTH];
    fq_entry_t        mem_d [DEPTH];

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) begin
                for (int unsigned i = 0; i < WR_N; i++) begin
                    mem_d[wr_ptr_q[IDX_W-1:0] + IDX_W'(i)] = wr_data[i];
                end
                wr_ptr_d = wr_ptr_q + PTR_W'(WR_N);
            end
            if (rd_en && !empty) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding memory request, redirect/squash control, FIFO to decode.
// Optional FETCH_QUEUE_PERF_EN adds Stall_cycles and Redirects counters.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned FETCH_W  = 2,
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          CLK,
    input  logic          RESET,
    fetch_queue_if.master bus
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]   Stall_cycles,
    output logic [31:0]   Redirects
`endif
);
    localparam int unsigned CNT_W        = $clog2(DEPTH) + 1;
    localparam logic [31:0] FETCH_STRIDE = 32'(INSTR_BYTES * FETCH_W);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;

    fq_entry_t        wr_data [FETCH_W];
    fq_entry_t        head;
    logic             empty, full, enq, deq;
    logic [CNT_W-1:0] count, free;
    logic             redirect, req_valid;

    assign redirect = bus.Request_Alt_PC;
    assign free     = CNT_W'(DEPTH) - count;
    assign deq      = !empty && !bus.STALL;

    always_comb begin
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            wr_data[i].instr = bus.Resp_data[32*i +: 32];
            wr_data[i].pc    = inflight_pc_q + 32'(INSTR_BYTES * i);
        end
    end

    // WAIT+redirect leaves via SQUASH unless the response lands in the same cycle,
    // in which case that response is the one being dropped and nothing stays in flight.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        req_valid     = 1'b0;
        enq           = 1'b0;
        case (state_q)
            FS_RESET: state_d = FS_IDLE;
            FS_IDLE: begin
                req_valid = !redirect && !full && (free >= CNT_W'(FETCH_W));
                if (req_valid && bus.Req_ready) begin
                    state_d       = FS_WAIT;
                    inflight_pc_d = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + FETCH_STRIDE;
                end
            end
            FS_WAIT: begin
                if (redirect) begin
                    state_d = bus.Resp_valid ? FS_IDLE : FS_SQUASH;
                end else if (bus.Resp_valid) begin
                    state_d = FS_IDLE;
                    enq     = 1'b1;
                end
            end
            FS_SQUASH: begin
                if (bus.Resp_valid) begin
                    state_d = FS_IDLE;
                end
            end
            default: state_d = FS_RESET;
        endcase
        if (redirect) begin
            fetch_pc_d = bus.Alt_PC & ~32'h3;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= FS_RESET;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .WR_N  (FETCH_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET),
        .flush   (redirect),
        .wr_en   (enq),
        .wr_data (wr_data),
        .rd_en   (deq),
        .rd_data (head),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    assign bus.Req_valid      = req_valid;
    assign bus.Req_addr       = fetch_pc_q;
    assign bus.Out_valid      = !empty;
    assign bus.Instr1_OUT     = empty ? '0 : head.instr;
    assign bus.Instr_PC_OUT   = empty ? '0 : head.pc;
    assign bus.Instr_PC_Plus4 = empty ? '0 : head.pc + 32'(INSTR_BYTES);

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] redirects_q, redirects_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + ((!empty && bus.STALL) ? 32'd1 : 32'd0);
        redirects_d    = redirects_q + (redirect ? 32'd1 : 32'd0);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_cycles_q <= '0;
            redirects_q    <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            redirects_q    <= redirects_d;
        end
    end

    assign Stall_cycles = stall_cycles_q;
    assign Redirects    = redirects_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner sequences, random run vs queue model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned FW  = 2;
    localparam int unsigned DP  = 8;
    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    fetch_queue_if #(.FETCH_W(FW)) bus ();

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stall_cycles, redirects;
`endif

    fetch_queue #(
        .FETCH_W  (FW),
        .DEPTH    (DP),
        .RESET_PC (RPC)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .Stall_cycles (stall_cycles),
        .Redirects    (redirects)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of {instr, pc} plus fetch pointer and in-flight bookkeeping.
    fq_entry_t   m_q[$];
    logic [31:0] m_pc, m_inf_pc;
    bit          m_inf, m_sq, m_started;
    int unsigned m_stalls, m_redirs;

    // Memory stimulus
    bit          mem_pend;
    int unsigned mem_cnt;
    logic [31:0] mem_addr;

    // Current-cycle inputs
    bit          cur_stall, cur_redir, cur_ready, cur_resp;
    logic [31:0] cur_alt;
    int unsigned cur_lat;
    bit          exp_rv;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_1234;
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic        ov;
        logic [31:0] ei, ep, e4;
        ov = (m_q.size() > 0);
        ei = ov ? m_q[0].instr : 32'h0;
        ep = ov ? m_q[0].pc : 32'h0;
        e4 = ov ? m_q[0].pc + 32'd4 : 32'h0;
        n_checks++;
        if (bus.Req_valid !== exp_rv || bus.Req_addr !== m_pc || bus.Out_valid !== ov ||
            bus.Instr1_OUT !== ei || bus.Instr_PC_OUT !== ep || bus.Instr_PC_Plus4 !== e4) begin
            n_fail++;
            $display("FAIL %s t=%0t: got rv=%b addr=%h ov=%b instr=%h pc=%h p4=%h expected rv=%b addr=%h ov=%b instr=%h pc=%h p4=%h",
                     tag, $time, bus.Req_valid, bus.Req_addr, bus.Out_valid, bus.Instr1_OUT,
                     bus.Instr_PC_OUT, bus.Instr_PC_Plus4, exp_rv, m_pc, ov, ei, ep, e4);
        end
`ifdef FETCH_QUEUE_PERF_EN
        check32({tag, "_stall_cycles"}, stall_cycles, m_stalls);
        check32({tag, "_redirects"}, redirects, m_redirs);
`endif
    endtask

    // Drive one cycle's inputs (at posedge+1) and compare against the model at posedge+2.
    task automatic apply(input bit stall, input bit redir, input logic [31:0] alt,
                         input bit ready, input int unsigned lat, input bit spur);
        cur_stall = stall; cur_redir = redir; cur_alt = alt; cur_ready = ready; cur_lat = lat;
        cur_resp  = mem_pend && (mem_cnt == 0);
        bus.STALL          = stall;
        bus.Request_Alt_PC = redir;
        bus.Alt_PC         = alt;
        bus.Req_ready      = ready;
        if (cur_resp) begin
            bus.Resp_valid = 1'b1;
            for (int i = 0; i < FW; i++) bus.Resp_data[32*i +: 32] = mem_word(mem_addr + 32'(4*i));
        end else if (spur && !mem_pend) begin
            bus.Resp_valid = 1'b1;
            for (int i = 0; i < FW; i++) bus.Resp_data[32*i +: 32] = $urandom;
        end else begin
            bus.Resp_valid = 1'b0;
            bus.Resp_data  = '0;
        end
        #1;
        exp_rv = m_started && !m_inf && !redir && ((DP - m_q.size()) >= FW);
        check_model("cycle");
    endtask

    task automatic advance();
        bit rv_in;
        rv_in = bus.Resp_valid;
        if (m_q.size() > 0 && cur_stall) m_stalls++;
        if (cur_redir) m_redirs++;
        if (cur_resp) mem_pend = 0;
        else if (mem_pend && mem_cnt > 0) mem_cnt--;
        if (exp_rv && cur_ready) begin
            mem_pend = 1; mem_cnt = cur_lat; mem_addr = m_pc;
        end
        if (cur_redir) begin
            m_q.delete();
            m_pc = cur_alt & ~32'h3;
            if (m_inf) begin
                if (rv_in) begin m_inf = 0; m_sq = 0; end
                else m_sq = 1;
            end
        end else begin
            if (m_q.size() > 0 && !cur_stall) void'(m_q.pop_front());
            if (rv_in && m_inf) begin
                if (!m_sq)
                    for (int i = 0; i < FW; i++)
                        m_q.push_back('{instr: mem_word(m_inf_pc + 32'(4*i)), pc: m_inf_pc + 32'(4*i)});
                m_inf = 0; m_sq = 0;
            end
            if (exp_rv && cur_ready) begin
                m_inf = 1; m_inf_pc = m_pc; m_pc = m_pc + 32'(4*FW);
            end
        end
        m_started = 1;
        @(posedge CLK); #1;
    endtask

    task automatic step(input bit stall, input bit redir, input logic [31:0] alt,
                        input bit ready, input int unsigned lat);
        apply(stall, redir, alt, ready, lat, 1'b0);
        advance();
    endtask

    // Asserts RESET at posedge+1, checks outputs drop at once, holds two edges, releases at posedge+1.
    task automatic do_reset();
        bus.STALL = 0; bus.Request_Alt_PC = 0; bus.Alt_PC = '0;
        bus.Req_ready = 0; bus.Resp_valid = 0; bus.Resp_data = '0;
        RESET = 1'b0;
        #1;
        m_q.delete(); m_pc = RPC; m_inf = 0; m_sq = 0; m_started = 0;
        m_stalls = 0; m_redirs = 0; exp_rv = 0;
        check32("reset_req_valid", {31'd0, bus.Req_valid}, 32'd0);
        check32("reset_out_valid", {31'd0, bus.Out_valid}, 32'd0);
        check32("reset_instr", bus.Instr1_OUT, 32'd0);
        check32("reset_pc", bus.Instr_PC_OUT, 32'd0);
        check32("reset_pc_plus4", bus.Instr_PC_Plus4, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        check_model("reset_hold");
        mem_cnt = 0;
        RESET = 1'b1;
    endtask

    typedef struct {
        bit          stall;
        bit          ready;
        bit          rv;
        logic [31:0] addr;
        bit          ov;
        logic [31:0] pc;
    } t21_row_t;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t21_row_t    t21 [8];
        int          acc, ndeq, found;
        logic [31:0] stale_pc;

        t21[0] = '{0, 1, 0, 32'hBFC0_0000, 0, 32'h0};
        t21[1] = '{0, 1, 1, 32'hBFC0_0000, 0, 32'h0};
        t21[2] = '{0, 1, 0, 32'hBFC0_0008, 0, 32'h0};
        t21[3] = '{0, 1, 1, 32'hBFC0_0008, 1, 32'hBFC0_0000};
        t21[4] = '{0, 1, 0, 32'hBFC0_0010, 1, 32'hBFC0_0004};
        t21[5] = '{0, 1, 1, 32'hBFC0_0010, 1, 32'hBFC0_0008};
        t21[6] = '{0, 1, 0, 32'hBFC0_0018, 1, 32'hBFC0_000C};
        t21[7] = '{0, 1, 1, 32'hBFC0_0018, 1, 32'hBFC0_0010};

        mem_pend = 0; mem_cnt = 0; mem_addr = '0;
        #2;
        do_reset();

        // Startup with a 1-cycle memory
        for (int r = 0; r < 8; r++) begin
            apply(t21[r].stall, 1'b0, 32'h0, t21[r].ready, 0, 1'b0);
            check32("t21_req_valid", {31'd0, bus.Req_valid}, {31'd0, t21[r].rv});
            check32("t21_req_addr", bus.Req_addr, t21[r].addr);
            check32("t21_out_valid", {31'd0, bus.Out_valid}, {31'd0, t21[r].ov});
            if (t21[r].ov) begin
                check32("t21_pc", bus.Instr_PC_OUT, t21[r].pc);
                check32("t21_pc_plus4", bus.Instr_PC_Plus4, t21[r].pc + 32'd4);
                check32("t21_instr", bus.Instr1_OUT, mem_word(t21[r].pc));
            end else begin
                check32("t21_instr_empty", bus.Instr1_OUT, 32'd0);
            end
            advance();
        end

        // STALL held 10 cycles: queue fills, then drains in order
        do_reset();
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            apply(1'b1, 1'b0, 32'h0, 1'b1, 0, 1'b0);
            if (bus.Req_valid && bus.Req_ready) acc++;
            if (c == 9) begin
                check32("stall_full_req_valid", {31'd0, bus.Req_valid}, 32'd0);
                check32("stall_full_out_valid", {31'd0, bus.Out_valid}, 32'd1);
            end
            advance();
        end
        check32("stall_requests_accepted", acc, 32'd4);
        ndeq = 0;
        for (int c = 0; c < 30 && ndeq < 8; c++) begin
            apply(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
            if (bus.Out_valid) begin
                check32("stall_drain_pc", bus.Instr_PC_OUT, RPC + 32'(4*ndeq));
                check32("stall_drain_instr", bus.Instr1_OUT, mem_word(RPC + 32'(4*ndeq)));
                ndeq++;
            end
            advance();
        end
        check32("stall_drain_count", ndeq, 32'd8);

        // Redirect while a request is in flight
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1);
        step(1'b0, 1'b1, 32'h0040_0003, 1'b1, 0);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
        check32("redir_stale_resp_present", {31'd0, bus.Resp_valid}, 32'd1);
        check32("redir_no_req_while_squashed", {31'd0, bus.Req_valid}, 32'd0);
        advance();
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            apply(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
            if (bus.Req_valid) begin
                check32("redir_next_req_addr", bus.Req_addr, 32'h0040_0000);
                found = 1;
            end
            advance();
        end
        check32("redir_req_seen", found, 32'd1);
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            apply(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
            if (bus.Out_valid) begin
                check32("redir_first_out_pc", bus.Instr_PC_OUT, 32'h0040_0000);
                found = 1;
            end
            advance();
        end
        check32("redir_out_seen", found, 32'd1);

        // Redirect, response and STALL in one cycle
        do_reset();
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 32'h0, 1'b1, 0);
        apply(1'b1, 1'b1, 32'h0000_1000, 1'b1, 0, 1'b0);
        check32("rrs_resp_present", {31'd0, bus.Resp_valid}, 32'd1);
        check32("rrs_out_valid_before", {31'd0, bus.Out_valid}, 32'd1);
        advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
        check32("rrs_out_valid_after", {31'd0, bus.Out_valid}, 32'd0);
        check32("rrs_req_addr", bus.Req_addr, 32'h0000_1000);
        advance();
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            apply(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
            if (bus.Out_valid) begin
                check32("rrs_first_out_pc", bus.Instr_PC_OUT, 32'h0000_1000);
                found = 1;
            end
            advance();
        end
        check32("rrs_out_seen", found, 32'd1);

        // Reset in the middle of a request; the late response must be ignored
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1, 3);
        step(1'b0, 1'b0, 32'h0, 1'b1, 3);
        stale_pc = mem_addr;
        check32("midreset_pending_addr", stale_pc, RPC);
        step(1'b0, 1'b0, 32'h0, 1'b1, 3);
        do_reset();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
        check32("midreset_stray_resp", {31'd0, bus.Resp_valid}, 32'd1);
        check32("midreset_no_req_c0", {31'd0, bus.Req_valid}, 32'd0);
        advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
        check32("midreset_first_req_valid", {31'd0, bus.Req_valid}, 32'd1);
        check32("midreset_first_req_addr", bus.Req_addr, RPC);
        check32("midreset_out_valid", {31'd0, bus.Out_valid}, 32'd0);
        advance();

`ifdef FETCH_QUEUE_PERF_EN
        // 3 stall cycles with valid output, then 2 redirects
        do_reset();
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 32'h0, 1'b1, 0);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 32'h0, 1'b1, 0);
        step(1'b0, 1'b1, 32'h0000_2000, 1'b1, 0);
        step(1'b0, 1'b1, 32'h0000_3000, 1'b1, 0);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
        check32("perf_stall_cycles", stall_cycles, 32'd3);
        check32("perf_redirects", redirects, 32'd2);
        advance();
`endif

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            apply(($urandom_range(2) == 0), ($urandom_range(24) == 0), $urandom,
                  ($urandom_range(3) != 0), $urandom_range(3), ($urandom_range(15) == 0));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
